csa_multiword_seq: RTL and testbench

- Sequencing stage wrapped around the 32-bit carry-select adder.
- Accepts a stream of operand word pairs (least-significant word first) forming one multi-word addition.
- Drives the adder's a/b/cin inputs from a registered operand stage.
- Captures sum/cout into a registered result stage and chains the carry between words, giving one word per cycle of N×32-bit addition with valid/ready flow control.

---
 rtl/csa_multiword_seq.sv | 185 ++++++++++++++++++
 tb/tb_csa_multiword_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_multiword_seq.sv
// Multi-word addition sequencer around an external carry-select adder.
// It uses a registered operand stage and a registered result stage, and it chains the carry from one word to the next.
module csa_multiword_seq #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_cin,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_err
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d, op_first_q, op_first_d;
  logic              op_last_q, op_last_d, op_err_q, op_err_d;
  logic              op_valid_q, op_valid_d;
  logic [IDX_W-1:0]  op_idx_q, op_idx_d;
  logic              carry_q, carry_d;
  logic              in_pkt_q, in_pkt_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_sum_q, out_sum_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d, out_cout_q, out_cout_d;
  logic              out_ovf_q, out_ovf_d, out_err_q, out_err_d;

  logic op_adv, accept, at_max, eff_last;

  // Handshake: the operand stage advances whenever the result stage is free or draining.
  always_comb begin
    op_adv   = op_valid_q & (~out_valid_q | out_ready);
    in_ready = ~op_valid_q | op_adv;
    accept   = in_valid & in_ready;
    at_max   = (cnt_q == IDX_MAX);
    eff_last = in_last | at_max;
  end

  // Adder drive: the first word of a packet takes the packet carry-in, and later words take the chained carry.
  always_comb begin
    if (op_valid_q) begin
      add_a   = op_a_q;
      add_b   = op_b_q;
      add_cin = op_first_q ? op_cin_q : carry_q;
    end else begin
      add_a   = {DATA_W{1'b0}};
      add_b   = {DATA_W{1'b0}};
      add_cin = 1'b0;
    end
  end

  // Operand stage and packet tracking next-state.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    op_first_d = op_first_q;
    op_last_d  = op_last_q;
    op_idx_d   = op_idx_q;
    op_err_d   = op_err_q;
    op_valid_d = op_valid_q;
    in_pkt_d   = in_pkt_q;
    cnt_d      = cnt_q;
    if (accept) begin
      op_a_d     = in_a;
      op_b_d     = in_b;
      op_cin_d   = in_cin;
      op_first_d = ~in_pkt_q;
      op_last_d  = eff_last;
      op_idx_d   = cnt_q;
      op_err_d   = at_max & ~in_last;
      op_valid_d = 1'b1;
      if (eff_last) begin
        in_pkt_d = 1'b0;
        cnt_d    = {IDX_W{1'b0}};
      end else begin
        in_pkt_d = 1'b1;
        cnt_d    = cnt_q + IDX_ONE;
      end
    end else if (op_adv) begin
      op_valid_d = 1'b0;
    end else begin
      op_valid_d = op_valid_q;
    end
  end

  // Result stage next-state: capture adder outputs and carry only when the operand word moves forward.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    carry_d     = carry_q;
    if (op_adv) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_idx_d   = op_idx_q;
      out_last_d  = op_last_q;
      out_err_d   = op_err_q;
      out_cout_d  = op_last_q & add_cout;
      out_ovf_d   = op_last_q & (op_a_q[DATA_W-1] == op_b_q[DATA_W-1]) &
                    (add_sum[DATA_W-1] != op_a_q[DATA_W-1]);
      carry_d     = add_cout;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q      <= {DATA_W{1'b0}};
      op_b_q      <= {DATA_W{1'b0}};
      op_cin_q    <= 1'b0;
      op_first_q  <= 1'b0;
      op_last_q   <= 1'b0;
      op_idx_q    <= {IDX_W{1'b0}};
      op_err_q    <= 1'b0;
      op_valid_q  <= 1'b0;
      carry_q     <= 1'b0;
      in_pkt_q    <= 1'b0;
      cnt_q       <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
      out_sum_q   <= {DATA_W{1'b0}};
      out_idx_q   <= {IDX_W{1'b0}};
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_first_q  <= op_first_d;
      op_last_q   <= op_last_d;
      op_idx_q    <= op_idx_d;
      op_err_q    <= op_err_d;
      op_valid_q  <= op_valid_d;
      carry_q     <= carry_d;
      in_pkt_q    <= in_pkt_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// Self-checking bench for csa_multiword_seq.
// Stimulus comes from a vector table plus hand-written corner sequences, and results are checked against a scoreboard queue.
module tb_csa_multiword_seq;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, last;
    logic [31:0] sum;
    logic [2:0]  idx;
    logic        lst, cout, ovf, err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_cin, in_last;
  logic [31:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic        add_cin, add_cout, out_valid, out_ready;
  logic [2:0]  out_idx;
  logic        out_last, out_cout, out_ovf, out_err;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[16];
  vec_t bp[4];
  vec_t mon_e;

  always #5 clk = ~clk;

  // Behavioural 32-bit adder standing in for the carry-select adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  csa_multiword_seq #(.DATA_W(32), .MAX_WORDS(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_idx(out_idx), .out_last(out_last), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic last, input logic [31:0] sum, input logic [2:0] idx,
                              input logic lst, input logic cout, input logic ovf, input logic err);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.last = last; v.sum = sum; v.idx = idx;
    v.lst = lst; v.cout = cout; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  task automatic send(input vec_t v);
    int n = 0;
    bit done = 1'b0;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_last = v.last; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d words pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result word transfers when out_valid and out_ready are both high
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word: got sum %h, required no output", out_sum);
      end else begin
        mon_e = sb.pop_front();
        chk("out_sum",  out_sum, mon_e.sum);
        chk("out_idx",  32'(out_idx), 32'(mon_e.idx));
        chk("out_last", 32'(out_last), 32'(mon_e.lst));
        chk("out_cout", 32'(out_cout), 32'(mon_e.cout));
        chk("out_ovf",  32'(out_ovf), 32'(mon_e.ovf));
        chk("out_err",  32'(out_err), 32'(mon_e.err));
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic        ps_full = 1'b0;
  logic        saw_ready_low = 1'b0;
  logic [31:0] ps_sum, ps_a, ps_b;
  logic [2:0]  ps_idx;
  logic        ps_cin;

  // Stall checker: outputs must hold across a stalled edge, and adder inputs must also hold when the operand stage was full
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", out_sum, ps_sum);
      chk("stall_idx", 32'(out_idx), 32'(ps_idx));
      if (ps_full) begin
        chk("stall_add_a", add_a, ps_a);
        chk("stall_add_b", add_b, ps_b);
        chk("stall_add_cin", 32'(add_cin), 32'(ps_cin));
      end
    end
    prev_stall = (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b0);
    if (prev_stall) begin
      ps_sum = out_sum; ps_idx = out_idx; ps_a = add_a; ps_b = add_b; ps_cin = add_cin;
      ps_full = (in_ready === 1'b0);
      if (in_ready === 1'b0) saw_ready_low = 1'b1;
    end else begin
      ps_full = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ra, rb;
    logic [128:0] rs;
    vec_t v;

    // 1-word, 2-word, overflow, ignored in_cin, then truncation at 8 words
    tbl[0]  = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(32'h00000003, 32'h00000004, 1'b1, 1'b1, 32'h00000007, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 7; i++)
      tbl[7+i] = mk(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[15] = mk(32'h00000005, 32'h00000006, 1'b0, 1'b1, 32'h0000000B, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_cin = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_flags", {26'd0, out_idx, out_last, out_cout, out_ovf, out_err}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) send(tbl[i]);
    drain();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // 4-word 128-bit add with carry-in 1 under 3 cycles of backpressure
    ra = {$urandom, $urandom, 32'hFFFFFFFF, 32'hFFFFFFFF};
    rb = {$urandom, $urandom, $urandom, $urandom};
    rs = {1'b0, ra} + {1'b0, rb} + 129'd1;
    for (int i = 0; i < 4; i++) begin
      v.a = ra[32*i +: 32]; v.b = rb[32*i +: 32];
      v.cin = (i == 0); v.last = (i == 3);
      v.sum = rs[32*i +: 32]; v.idx = 3'(i); v.lst = (i == 3);
      v.cout = (i == 3) ? rs[128] : 1'b0;
      v.ovf = (i == 3) ? ((ra[127] == rb[127]) && (rs[127] != ra[127])) : 1'b0;
      v.err = 1'b0;
      bp[i] = v;
    end
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i]);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_low", 32'(saw_ready_low), 32'd1);

    // Reset after word 1 of a 3-word packet while the chained carry is 1
    send(mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(mk(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
